serial_deser: RTL and testbench

Serial-to-parallel deserializer consuming the single-bit registered output of the `DFF` sampling stage. It assembles `WIDTH` strobed bits, MSB first, into a word and presents it on a one-word valid/ready output buffer. Overflow is flagged rather than stalling the serial source. Shifting continues while a completed word waits, so one word of slack exists.

---
 rtl/serial_deser_pkg.sv | 17 +
 rtl/deser_bit_cnt.sv | 28 ++
 rtl/serial_deser.sv | 134 +++++++++++++
 tb/tb_serial_deser.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/serial_deser_pkg.sv
// rtl/serial_deser_pkg.sv - shared types and constants for the serial deserializer
package serial_deser_pkg;

  // Word assembly phases: data bits, then (optionally) one parity bit
  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to hold a count of 0..w
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/deser_bit_cnt.sv
// rtl/deser_bit_cnt.sv - wrapping bit counter with enable and terminal-count flag
module deser_bit_cnt #(
  parameter int MAX = 8,
  parameter int CW  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  logic [CW-1:0] count;

  assign tc = (count == LAST);

  // Count enabled strobes, wrapping to zero after the last bit of a word
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (tc) count <= '0;
      else    count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_deser.sv
// rtl/serial_deser.sv - MSB-first serial-to-parallel deserializer with one-word output buffer (optional parity: SERIAL_DESER_PARITY_EN)
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  input  logic             d_en,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           next_state;
  logic             bit_tc;
  logic             cnt_en;
  logic             complete;
  logic [WIDTH-1:0] word_data;
  logic             word_perr;
  logic             perr_q;

`ifdef SERIAL_DESER_PARITY_EN
  // Full word is held in the shift register while the parity bit arrives
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;

  assign sr_next   = {sr[WIDTH-2:0], d};
  assign word_data = sr;
  assign word_perr = (^sr) ^ d;
`else
  // Completion uses the incoming bit directly, so only WIDTH-1 bits are stored
  logic [WIDTH-2:0] sr;
  logic [WIDTH-2:0] sr_next;

  assign word_data = {sr, d};
  assign sr_next   = word_data[WIDTH-2:0];
  assign word_perr = 1'b0;
`endif

  deser_bit_cnt #(
    .MAX (WIDTH),
    .CW  (CW)
  ) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .tc    (bit_tc)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_DATA;
    else       state <= next_state;
  end

  // FSM next-state: leave S_DATA after the last data bit only when parity follows
  always_comb begin
    next_state = state;
    case (state)
      S_DATA: begin
`ifdef SERIAL_DESER_PARITY_EN
        if (d_en && bit_tc) next_state = S_PAR;
`else
        next_state = S_DATA;
`endif
      end
      S_PAR: begin
        if (d_en) next_state = S_DATA;
      end
      default: next_state = S_DATA;
    endcase
  end

  // FSM outputs: shift/count enable and word-complete pulse
  always_comb begin
    cnt_en   = 1'b0;
    complete = 1'b0;
    case (state)
      S_DATA: begin
        cnt_en = d_en;
`ifndef SERIAL_DESER_PARITY_EN
        complete = d_en && bit_tc;
`endif
      end
      S_PAR: begin
        complete = d_en;
      end
      default: begin
        cnt_en   = 1'b0;
        complete = 1'b0;
      end
    endcase
  end

  // Shift register: MSB-first, moves only on data strobes
  always_ff @(posedge clk) begin
    if (reset)       sr <= '0;
    else if (cnt_en) sr <= sr_next;
  end

  // Output buffer: load when empty or being drained, otherwise drop and flag overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      q_data  <= '0;
      q_valid <= 1'b0;
      perr_q  <= 1'b0;
      overrun <= 1'b0;
    end else if (complete) begin
      if (!q_valid || out_ready) begin
        q_data  <= word_data;
        q_valid <= 1'b1;
        perr_q  <= word_perr;
      end else begin
        overrun <= 1'b1;
      end
    end else if (q_valid && out_ready) begin
      q_valid <= 1'b0;
    end
  end

`ifdef SERIAL_DESER_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deser.sv
// tb/tb_serial_deser.sv - directed self-checking bench for serial_deser (WIDTH=8)
module tb_serial_deser;

  logic       clk = 1'b0;
  logic       reset;
  logic       d;
  logic       d_en;
  logic       out_ready;
  logic [7:0] q_data;
  logic       q_valid;
  logic       parity_err;
  logic       overrun;

  int vectors     = 0;
  int miscompares = 0;

  serial_deser #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .d_en       (d_en),
    .out_ready  (out_ready),
    .q_data     (q_data),
    .q_valid    (q_valid),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given inputs; returns 1 time unit after the edge
  task automatic step(input logic rst, input logic en, input logic bit_v, input logic rdy);
    reset     = rst;
    d_en      = en;
    d         = bit_v;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] data, input logic valid,
                          input logic perr, input logic ovr);
    chk({tag, "_data"}, 32'(q_data), 32'(data));
    chk({tag, "_valid"}, 32'(q_valid), 32'(valid));
    chk({tag, "_perr"}, 32'(parity_err), 32'(perr));
    chk({tag, "_ovr"}, 32'(overrun), 32'(ovr));
  endtask

  // Send one word MSB first (plus parity bit in the parity build), with random idle
  // gaps of 0..maxgap cycles during which d toggles; rdy_last applies on the final strobe
  task automatic send(input logic [7:0] w, input logic par, input int maxgap,
                      input logic rdy, input logic rdy_last, input logic pre_chk);
    int   nbits;
    logic b;
`ifdef SERIAL_DESER_PARITY_EN
    nbits = 9;
`else
    nbits = 8;
`endif
    for (int k = 0; k < nbits; k++) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, g[0], rdy);
      b = (k < 8) ? w[7-k] : par;
      if (k == nbits - 1) begin
        if (pre_chk) chk("pre_last_valid", 32'(q_valid), 32'(0));
        step(1'b0, 1'b1, b, rdy_last);
      end else begin
        step(1'b0, 1'b1, b, rdy);
      end
    end
  endtask

  initial begin
    reset = 1'b1; d = 1'b0; d_en = 1'b0; out_ready = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Basic word, valid for exactly one cycle
    send(8'hA5, 1'b0, 0, 1'b1, 1'b1, 1'b1);
    chk_outs("basic", 8'hA5, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic_valid_drop", 32'(q_valid), 32'(0));
    chk("basic_data_hold", 32'(q_data), 32'hA5);

    // Irregular strobe spacing with d toggling between strobes
    send(8'hA5, 1'b0, 3, 1'b1, 1'b1, 1'b1);
    chk_outs("irregular", 8'hA5, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("irregular_drain", 32'(q_valid), 32'(0));

    // Back-to-back words at full rate
    send(8'h3C, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk_outs("b2b_first", 8'h3C, 1'b1, 1'b0, 1'b0);
    send(8'hC3, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk_outs("b2b_second", 8'hC3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_drain", 32'(q_valid), 32'(0));

    // Backpressure: second word dropped, overrun sticky
    send(8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk_outs("bp_first", 8'hA5, 1'b1, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    chk_outs("bp_overrun", 8'hA5, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_outs("bp_accept", 8'hA5, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_ovr_sticky", 32'(overrun), 32'(1));

    // Reset clears the sticky overrun
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_outs("reset2", 8'h00, 1'b0, 1'b0, 1'b0);

    // Simultaneous accept and load
    send(8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk_outs("sim_held", 8'hA5, 1'b1, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    chk_outs("sim_load", 8'h3C, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sim_drain", 32'(q_valid), 32'(0));

    // Reset mid-word discards the partial word, even with a strobe present
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk_outs("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h0F, 1'b0, 0, 1'b1, 1'b1, 1'b1);
    chk_outs("after_reset", 8'h0F, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("after_reset_drain", 32'(q_valid), 32'(0));

`ifdef SERIAL_DESER_PARITY_EN
    // Even parity: 0xA5 has four ones
    send(8'hA5, 1'b0, 0, 1'b1, 1'b1, 1'b1);
    chk_outs("par_ok", 8'hA5, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send(8'hA5, 1'b1, 1, 1'b1, 1'b1, 1'b1);
    chk_outs("par_err", 8'hA5, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("par_drain", 32'(q_valid), 32'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
